// File: rtl/spi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_pkg : shared types and constants for the SPI slave             |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package spi_pkg;

  localparam int SPI_FRAME_BITS_DEFAULT = 64;
  localparam int SPI_CNT_W              = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_sync : multi-flop synchronizer with rise/fall edge detection   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module spi_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_slave : mode-0 SPI target with one-deep tx holding register    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module spi_slave
  import spi_pkg::*;
#(
  parameter int FRAME_BITS  = SPI_FRAME_BITS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  spi_c,
  input  logic                  spi_s,
  input  logic                  spi_dq0,
  output logic                  spi_dq1,
  input  logic [FRAME_BITS-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam logic [SPI_CNT_W-1:0] c_frame_cnt = SPI_CNT_W'(FRAME_BITS);
  localparam int                   c_flush_w   = $clog2(SYNC_STAGES + 2) + 1;
  localparam logic [c_flush_w-1:0] c_flush_cnt = c_flush_w'(SYNC_STAGES + 1);

  logic c_lvl, c_rise, c_fall;
  logic s_lvl, s_rise, s_fall;
  logic dq0_lvl, dq0_rise, dq0_fall;
  logic unused_sync;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_c (
    .clk(CLK), .rst_n(rst_n), .d(spi_c), .q(c_lvl), .rise(c_rise), .fall(c_fall)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_s (
    .clk(CLK), .rst_n(rst_n), .d(spi_s), .q(s_lvl), .rise(s_rise), .fall(s_fall)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_dq0 (
    .clk(CLK), .rst_n(rst_n), .d(spi_dq0), .q(dq0_lvl), .rise(dq0_rise), .fall(dq0_fall)
  );

  assign unused_sync = c_lvl ^ dq0_rise ^ dq0_fall;

  spi_state_e              state_q, state_d;
  logic [FRAME_BITS-1:0]   hold_q, hold_d;
  logic                    hold_full_q, hold_full_d;
  logic [FRAME_BITS-1:0]   tx_sh_q, tx_sh_d;
  logic [FRAME_BITS-1:0]   rx_sh_q, rx_sh_d;
  logic [SPI_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]   rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    frame_err_q, frame_err_d;
  logic                    tx_underrun_q, tx_underrun_d;
  logic [c_flush_w-1:0]    flush_cnt_q, flush_cnt_d;
  logic                    armed_q, armed_d;
  logic                    accept;

  assign accept = tx_valid & ~hold_full_q;

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    tx_sh_d       = tx_sh_q;
    rx_sh_d       = rx_sh_q;
    bit_cnt_d     = bit_cnt_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    frame_err_d   = 1'b0;
    tx_underrun_d = 1'b0;
    flush_cnt_d   = (flush_cnt_q == c_flush_cnt) ? flush_cnt_q : flush_cnt_q + 1'b1;
    // A frame already running when reset releases must not be picked up:
    // arm only once the synchronizers have flushed and slave select reads high.
    armed_d       = armed_q | ((flush_cnt_q == c_flush_cnt) & s_lvl);

    // Accept is only possible while empty and LOAD only drains when full,
    // so a word accepted during LOAD stays for the next frame.
    if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end else if (state_q == ST_LOAD) begin
      hold_full_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        tx_sh_d = '0;
        if (s_fall && armed_q) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        tx_sh_d       = hold_full_q ? hold_q : '0;
        tx_underrun_d = ~hold_full_q;
        rx_sh_d       = '0;
        bit_cnt_d     = '0;
        state_d       = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (bit_cnt_q == c_frame_cnt) begin
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
          state_d    = ST_DONE;
        end else if (s_rise) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          if (c_rise) begin
            rx_sh_d   = {rx_sh_q[FRAME_BITS-2:0], dq0_lvl};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
          if (c_fall) begin
            tx_sh_d = {tx_sh_q[FRAME_BITS-2:0], 1'b0};
          end
        end
      end
      ST_DONE: begin
        if (s_lvl) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      tx_sh_q       <= '0;
      rx_sh_q       <= '0;
      bit_cnt_q     <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      tx_underrun_q <= 1'b0;
      flush_cnt_q   <= '0;
      armed_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      tx_sh_q       <= tx_sh_d;
      rx_sh_q       <= rx_sh_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      tx_underrun_q <= tx_underrun_d;
      flush_cnt_q   <= flush_cnt_d;
      armed_q       <= armed_d;
    end
  end

  assign spi_dq1     = (state_q == ST_SHIFT) ? tx_sh_q[FRAME_BITS-1] : 1'b0;
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign tx_underrun = tx_underrun_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_spi_slave : directed frame vectors for spi_slave (mode 0)       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_spi_slave;

  localparam int FB   = 64;
  localparam int SYNC = 2;
  localparam int HALF = 5;

  logic          CLK = 1'b0;
  logic          rst_n, spi_c, spi_s, spi_dq0, spi_dq1;
  logic [FB-1:0] tx_data, rx_data;
  logic          tx_valid, tx_ready, rx_valid, frame_err, tx_underrun, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt_rxv = 0;
  int cnt_err = 0;
  int cnt_und = 0;

  typedef struct {
    bit           load_tx;
    logic [63:0]  tx;
    bit           nxt_en;
    logic [63:0]  nxt;
    logic [63:0]  mosi;
    int           nbits;
    int           rst_at;
    logic [127:0] exp_miso;
    logic [63:0]  exp_rx;
    int           exp_rxv;
    int           exp_err;
    int           exp_und;
  } vec_t;

  vec_t tbl [9];

  spi_slave #(.FRAME_BITS(FB), .SYNC_STAGES(SYNC)) dut (
    .CLK(CLK), .rst_n(rst_n), .spi_c(spi_c), .spi_s(spi_s), .spi_dq0(spi_dq0),
    .spi_dq1(spi_dq1), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .tx_underrun(tx_underrun), .busy(busy)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (rx_valid)    cnt_rxv++;
    if (frame_err)   cnt_err++;
    if (tx_underrun) cnt_und++;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] w);
    int k = 0;
    @(negedge CLK);
    tx_data  = w;
    tx_valid = 1'b1;
    while (!tx_ready && k < 50) begin
      @(negedge CLK);
      k++;
    end
    check("push_ready", 128'(tx_ready), 128'(1));
    @(negedge CLK);
    tx_valid = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    logic [127:0] cap = '0;
    logic [63:0]  m;
    int rxv0 = cnt_rxv;
    int err0 = cnt_err;
    int und0 = cnt_und;
    int k;
    if (v.load_tx) push(v.tx);
    @(negedge CLK);
    spi_c = 1'b0;
    spi_s = 1'b0;
    k = 0;
    while (!busy && k < 20) begin
      @(negedge CLK);
      k++;
    end
    check({tag, "_busy_start"}, 128'(busy), 128'(1));
    if (v.nxt_en) begin
      // busy has just risen: the DUT is in LOAD and the holding register is still full
      tx_data  = v.nxt;
      tx_valid = 1'b1;
      k = 0;
      while (!tx_ready && k < 20) begin
        @(negedge CLK);
        k++;
      end
      check({tag, "_nxt_ready"}, 128'(tx_ready), 128'(1));
      @(negedge CLK);
      tx_valid = 1'b0;
    end
    repeat (4) @(negedge CLK);
    for (int i = 0; i < v.nbits; i++) begin
      if (v.rst_at > 0 && i == v.rst_at) begin
        rst_n = 1'b0;
        repeat (2) @(negedge CLK);
        rst_n = 1'b1;
      end
      m = v.mosi << i;
      spi_dq0 = (i < 64) ? m[63] : 1'b1;
      repeat (HALF) @(negedge CLK);
      cap   = {cap[126:0], spi_dq1};
      spi_c = 1'b1;
      repeat (HALF) @(negedge CLK);
      spi_c = 1'b0;
    end
    repeat (HALF) @(negedge CLK);
    check({tag, "_miso"}, cap, v.exp_miso);
    spi_s = 1'b1;
    repeat (SYNC + 2) @(negedge CLK);
    check({tag, "_busy_end"}, 128'(busy), 128'(0));
    repeat (6) @(negedge CLK);
    check({tag, "_rx_data"}, 128'(rx_data), 128'(v.exp_rx));
    check({tag, "_rx_valid_cnt"}, 128'(cnt_rxv - rxv0), 128'(v.exp_rxv));
    check({tag, "_frame_err_cnt"}, 128'(cnt_err - err0), 128'(v.exp_err));
    check({tag, "_underrun_cnt"}, 128'(cnt_und - und0), 128'(v.exp_und));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t hv;
    rst_n    = 1'b0;
    spi_c    = 1'b0;
    spi_s    = 1'b1;
    spi_dq0  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;

    //          load tx                      nxt  next word                  mosi                    bits rst  exp miso                                          exp rx                rxv err und
    tbl[0] = '{1'b1, 64'hA5A5_0000_FFFF_1234, 1'b0, 64'h0,                    64'hDEAD_BEEF_0123_4567, 64, 0, {64'd0, 64'hA5A5_0000_FFFF_1234},           64'hDEAD_BEEF_0123_4567, 1, 0, 0};
    tbl[1] = '{1'b0, 64'h0,                    1'b0, 64'h0,                    64'h0123_4567_89AB_CDEF, 64, 0, 128'd0,                                       64'h0123_4567_89AB_CDEF, 1, 0, 1};
    tbl[2] = '{1'b1, 64'h1111_2222_3333_4444, 1'b0, 64'h0,                    64'hFFFF_FFFF_FFFF_FFFF, 20, 0, {108'd0, 20'h11112},                        64'h0123_4567_89AB_CDEF, 0, 1, 0};
    tbl[3] = '{1'b1, 64'hCAFE_F00D_1357_9BDF, 1'b0, 64'h0,                    64'hFEDC_BA98_7654_3210, 70, 0, {58'd0, 64'hCAFE_F00D_1357_9BDF, 6'd0},     64'hFEDC_BA98_7654_3210, 1, 0, 0};
    tbl[4] = '{1'b1, 64'h8000_0000_0000_0001, 1'b0, 64'h0,                    64'hFFFF_FFFF_FFFF_FFFF, 64, 0, {64'd0, 64'h8000_0000_0000_0001},           64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0};
    tbl[5] = '{1'b1, 64'h0F0F_0F0F_F0F0_F0F0, 1'b1, 64'h1357_9BDF_2468_ACE0, 64'h5555_AAAA_5555_AAAA, 64, 0, {64'd0, 64'h0F0F_0F0F_F0F0_F0F0},           64'h5555_AAAA_5555_AAAA, 1, 0, 0};
    tbl[6] = '{1'b0, 64'h0,                    1'b0, 64'h0,                    64'hAAAA_5555_AAAA_5555, 64, 0, {64'd0, 64'h1357_9BDF_2468_ACE0},           64'hAAAA_5555_AAAA_5555, 1, 0, 0};
    tbl[7] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0,                    64'hFFFF_FFFF_FFFF_FFFF, 40, 30, {88'd0, 40'hFF_FFFF_FC00},                 64'h0,                   0, 0, 0};
    tbl[8] = '{1'b0, 64'h0,                    1'b0, 64'h0,                    64'h0000_0000_0000_0001, 64, 0, 128'd0,                                       64'h0000_0000_0000_0001, 1, 0, 1};

    repeat (3) @(negedge CLK);
    check("rst_tx_ready",    128'(tx_ready),    128'(1));
    check("rst_busy",        128'(busy),        128'(0));
    check("rst_rx_data",     128'(rx_data),     128'(0));
    check("rst_rx_valid",    128'(rx_valid),    128'(0));
    check("rst_frame_err",   128'(frame_err),   128'(0));
    check("rst_tx_underrun", 128'(tx_underrun), 128'(0));
    check("rst_miso",        128'(spi_dq1),     128'(0));
    rst_n = 1'b1;
    repeat (5) @(negedge CLK);

    // Holding register is one deep: a second offer while full must be refused.
    push(64'h0123_4567_89AB_CDEF);
    check("hold_full_ready", 128'(tx_ready), 128'(0));
    tx_data  = 64'hFFFF_0000_FFFF_0000;
    tx_valid = 1'b1;
    repeat (3) @(negedge CLK);
    tx_valid = 1'b0;
    check("hold_still_full", 128'(tx_ready), 128'(0));
    check("idle_miso", 128'(spi_dq1), 128'(0));
    hv = '{1'b0, 64'h0, 1'b0, 64'h0, 64'h0, 64, 0, {64'd0, 64'h0123_4567_89AB_CDEF}, 64'h0, 1, 0, 0};
    run_frame(hv, "hold");
    check("hold_drained_ready", 128'(tx_ready), 128'(1));

    for (int i = 0; i < 9; i++) begin
      run_frame(tbl[i], $sformatf("vec%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 64, meaning bits per SPI frame (range 8..64).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth on spi_c, spi_s and spi_dq0 (min 2).
REQ-003 SHALL have port CLK  input  1  system clock; one clock only; all logic on rising CLK.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port spi_c  input  1  SPI clock from initiator; async to CLK; idle low (mode 0).
REQ-006 SHALL have port spi_s  input  1  slave select from initiator; active-low; async.
REQ-007 SHALL have port spi_dq0  input  1  MOSI; initiator changes it on spi_c falling edge.
REQ-008 SHALL have port spi_dq1  output  1  MISO; initiator samples it on spi_c rising edge.
REQ-009 SHALL have port tx_data  input  FRAME_BITS  response word for the next frame.
REQ-010 SHALL have port tx_valid  input  1  tx_data valid; accepted when tx_valid && tx_ready.
REQ-011 SHALL have port tx_ready  output  1  one-deep holding register empty.
REQ-012 SHALL have port rx_data  output  FRAME_BITS  last complete received word; held until next complete frame.
REQ-013 SHALL have port rx_valid  output  1  one-CLK pulse when rx_data updates.
REQ-014 SHALL have port frame_err  output  1  one-CLK pulse: spi_s deasserted mid-frame.
REQ-015 SHALL have port tx_underrun  output  1  one-CLK pulse: frame started with holding register empty.
REQ-016 SHALL have port busy  output  1  high while state is not IDLE.

Function
REQ-017 SHALL sample spi_c, spi_s, spi_dq0 through SYNC_STAGES flops; edges detected from last two synchronized samples.
REQ-018 SHALL require spi_c high and low phases each >= 4 CLK periods; shorter is out of spec, behaviour undefined.
REQ-019 SHALL implement states IDLE, LOAD, SHIFT, DONE.
REQ-020 IDLE -> LOAD on synchronized spi_s falling edge; LOAD lasts exactly one CLK, then SHIFT.
REQ-021 In LOAD: holding register moves to shift register and tx_ready asserts next cycle; if holding empty, shift register loads all-zeros and tx_underrun pulses.
REQ-022 SHALL present shift-register MSB on spi_dq1 from the CLK after LOAD, before first spi_c rising edge.
REQ-023 On each synchronized spi_c rising edge in SHIFT: shift synchronized spi_dq0 into rx shift register LSB (MSB first on wire); increment 7-bit bit counter.
REQ-024 On each synchronized spi_c falling edge in SHIFT with bit counter < FRAME_BITS: shift tx register left one, zero-fill; spi_dq1 shows new MSB.
REQ-025 When bit counter reaches FRAME_BITS: SHIFT -> DONE; in DONE rx_data <= rx shift register and rx_valid pulses one CLK later than the FRAME_BITS-th sampling edge (+ sync latency).
REQ-026 After DONE, spi_dq1 SHALL drive 0 and further spi_c edges SHALL be ignored until spi_s rises; then -> IDLE.
REQ-027 spi_s rising in SHIFT (counter < FRAME_BITS): frame_err pulses, rx_data unchanged, no rx_valid, -> IDLE.
REQ-028 spi_dq1 SHALL be 0 whenever state is IDLE.
REQ-029 tx_valid accepted during any state while tx_ready high; simultaneous accept and LOAD: LOAD takes the old content (or underruns), new word stays in holding register for next frame.
REQ-030 Bit counter SHALL not wrap; saturates at FRAME_BITS.

Reset
REQ-031 On rst_n low at CLK rise: state IDLE, tx_ready 1, holding empty, rx_data 0, rx_valid 0, frame_err 0, tx_underrun 0, busy 0, spi_dq1 0, counters 0, synchronizers to idle levels (spi_c 0, spi_s 1).
REQ-032 Reset mid-frame SHALL abort without frame_err or rx_valid; after release, block waits for a fresh spi_s falling edge (a frame in progress is ignored until spi_s rises).

Structure
REQ-033 Shared package spi_pkg SHALL hold the state enumeration and SPI_FRAME_BITS_DEFAULT = 64.
REQ-034 One sub-module spi_sync SHALL implement the parameterized synchronizer plus rise/fall edge detect, instantiated three times.

Verification
REQ-035 Load tx_data 64'hA5A5_0000_FFFF_1234; master sends 64'hDEAD_BEEF_0123_4567 at spi_c = CLK/10 -> MISO bits equal 64'hA5A5_0000_FFFF_1234 MSB first; rx_data 64'hDEAD_BEEF_0123_4567; one rx_valid pulse.
REQ-036 No tx_valid before frame -> tx_underrun pulse, MISO all zeros, rx_data still correct.
REQ-037 spi_s raised after 20 bits -> frame_err pulse, rx_valid 0, rx_data keeps previous value, busy 0 within SYNC_STAGES+2 CLK.
REQ-038 70 spi_c cycles in one frame -> rx_data equals first 64 bits, MISO 0 for bits 65-70, single rx_valid.
REQ-039 rst_n low at bit 30, released, then full frame 64'h0000_0000_0000_0001 -> no frame_err, rx_data 64'h1.
REQ-040 Back-to-back frames with tx_valid for frame 2 asserted during LOAD of frame 1 -> frame 2 MISO carries the second word, no underrun.
